red_pitaya_sweep_block: RTL and testbench



---
 rtl/red_pitaya_sweep_block.sv | 261 ++++++++++++++++++++++++++
 tb/tb_red_pitaya_sweep_block.sv | 375 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/red_pitaya_sweep_block.sv
// Triangular sweep generator with threshold-triggered hold.
// A signed phase accumulator ramps between minval and maxval; dat_o is its
// integer part. When the monitored input crosses the threshold the sweep
// freezes (HOLD) until it is re-armed by a strobe or by the hold timer.
module red_pitaya_sweep_block #(
    parameter int FRACBITS = 16,
    parameter int STEPBITS = 24,
    parameter int HOLDBITS = 32
) (
    input  logic               clk_i,
    input  logic               rstn_i,
    input  logic signed [13:0] dat_i,
    output logic signed [13:0] dat_o,
    input  logic [15:0]        addr,
    input  logic               wen,
    input  logic               ren,
    output logic               ack,
    output logic [31:0]        rdata,
    input  logic [31:0]        wdata
);

    localparam int ACCW = 14 + FRACBITS;

    localparam logic [15:0] ADDR_CFG    = 16'h0100;
    localparam logic [15:0] ADDR_MIN    = 16'h0104;
    localparam logic [15:0] ADDR_MAX    = 16'h0108;
    localparam logic [15:0] ADDR_STEP   = 16'h010C;
    localparam logic [15:0] ADDR_THR    = 16'h0110;
    localparam logic [15:0] ADDR_HOLD   = 16'h0114;
    localparam logic [15:0] ADDR_STATUS = 16'h0118;
    localparam logic [15:0] ADDR_TRIGC  = 16'h011C;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_UP   = 2'd1,
        ST_DOWN = 2'd2,
        ST_HOLD = 2'd3
    } state_t;

    // configuration
    logic                 cfg_en_r;
    logic                 cfg_pol_r;
    logic                 cfg_auto_r;
    logic                 rearm_r;
    logic signed [13:0]   min_r;
    logic signed [13:0]   max_r;
    logic signed [13:0]   thr_r;
    logic [STEPBITS-1:0]  step_r;
    logic [HOLDBITS-1:0]  hold_r;

    // sweep state
    state_t               state_r, state_s;
    logic                 dir_r, dir_s;
    logic signed [ACCW-1:0] acc_r, acc_s;
    logic [HOLDBITS-1:0]  hold_cnt_r, hold_cnt_s, hold_lim_s;
    logic                 hold_hit_s;
    logic [15:0]          trig_cnt_r, trig_cnt_s, trig_inc_s;

    // trigger pipeline
    logic signed [13:0]   d1_r, d2_r;
    logic                 trig_r, trig_s;

    // limit arithmetic, one bit wider than the accumulator so nothing wraps
    logic signed [13:0]   hi_lim_s;
    logic signed [ACCW:0] lo_s, hi_s, acc_ext_s, step_ext_s, sum_s, diff_s;

    // bus
    logic                 ack_r;
    logic [31:0]          rdata_r, rd_mux_s;

    assign dat_o = acc_r[ACCW-1:FRACBITS];
    assign ack   = ack_r;
    assign rdata = rdata_r;

    // Limit values, candidate accumulator updates and hold-timer compare.
    always_comb begin
        // an empty or inverted range collapses both limits onto minval
        hi_lim_s   = (max_r > min_r) ? max_r : min_r;
        lo_s       = {min_r[13], min_r, {FRACBITS{1'b0}}};
        hi_s       = {hi_lim_s[13], hi_lim_s, {FRACBITS{1'b0}}};
        acc_ext_s  = {acc_r[ACCW-1], acc_r};
        step_ext_s = {{(ACCW + 1 - STEPBITS){1'b0}}, step_r};
        sum_s      = acc_ext_s + step_ext_s;
        diff_s     = acc_ext_s - step_ext_s;
        // hold_cycles of 0 behaves like 1
        hold_lim_s = (hold_r == {HOLDBITS{1'b0}}) ? {HOLDBITS{1'b0}} : (hold_r - HOLDBITS'(1));
        hold_hit_s = cfg_auto_r && (hold_cnt_r == hold_lim_s);
        trig_inc_s = (trig_cnt_r == 16'hFFFF) ? trig_cnt_r : (trig_cnt_r + 16'd1);
    end

    // Threshold crossing detect on the two registered input samples.
    always_comb begin
        if (cfg_pol_r) begin
            trig_s = (d2_r > thr_r) && (d1_r <= thr_r);
        end else begin
            trig_s = (d2_r < thr_r) && (d1_r >= thr_r);
        end
    end

    // Sweep FSM next-state, accumulator and counters.
    always_comb begin
        state_s    = state_r;
        acc_s      = acc_r;
        dir_s      = dir_r;
        hold_cnt_s = hold_cnt_r;
        trig_cnt_s = trig_cnt_r;
        if (!cfg_en_r) begin
            state_s    = ST_IDLE;
            acc_s      = lo_s[ACCW-1:0];
            dir_s      = 1'b0;
            hold_cnt_s = {HOLDBITS{1'b0}};
            trig_cnt_s = 16'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    acc_s   = lo_s[ACCW-1:0];
                    dir_s   = 1'b0;
                    state_s = ST_UP;
                end
                ST_UP: begin
                    if (trig_r) begin
                        // trigger beats the limit: freeze, but remember the turnaround
                        state_s    = ST_HOLD;
                        hold_cnt_s = {HOLDBITS{1'b0}};
                        trig_cnt_s = trig_inc_s;
                        if (sum_s >= hi_s) begin
                            dir_s = 1'b1;
                        end else begin
                            dir_s = dir_r;
                        end
                    end else if (sum_s >= hi_s) begin
                        acc_s   = hi_s[ACCW-1:0];
                        dir_s   = 1'b1;
                        state_s = ST_DOWN;
                    end else begin
                        acc_s = sum_s[ACCW-1:0];
                    end
                end
                ST_DOWN: begin
                    if (trig_r) begin
                        state_s    = ST_HOLD;
                        hold_cnt_s = {HOLDBITS{1'b0}};
                        trig_cnt_s = trig_inc_s;
                        if (diff_s <= lo_s) begin
                            dir_s = 1'b0;
                        end else begin
                            dir_s = dir_r;
                        end
                    end else if (diff_s <= lo_s) begin
                        acc_s   = lo_s[ACCW-1:0];
                        dir_s   = 1'b0;
                        state_s = ST_UP;
                    end else begin
                        acc_s = diff_s[ACCW-1:0];
                    end
                end
                ST_HOLD: begin
                    hold_cnt_s = hold_cnt_r + HOLDBITS'(1);
                    if (rearm_r || hold_hit_s) begin
                        state_s = dir_r ? ST_DOWN : ST_UP;
                    end else begin
                        state_s = ST_HOLD;
                    end
                end
                default: begin
                    state_s = ST_IDLE;
                end
            endcase
        end
    end

    // Sweep state registers.
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            state_r    <= ST_IDLE;
            acc_r      <= {ACCW{1'b0}};
            dir_r      <= 1'b0;
            hold_cnt_r <= {HOLDBITS{1'b0}};
            trig_cnt_r <= 16'd0;
        end else begin
            state_r    <= state_s;
            acc_r      <= acc_s;
            dir_r      <= dir_s;
            hold_cnt_r <= hold_cnt_s;
            trig_cnt_r <= trig_cnt_s;
        end
    end

    // Input sample pipeline and registered trigger.
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            d1_r   <= 14'sd0;
            d2_r   <= 14'sd0;
            trig_r <= 1'b0;
        end else begin
            d1_r   <= dat_i;
            d2_r   <= d1_r;
            trig_r <= trig_s;
        end
    end

    // Configuration register writes and the one-cycle rearm strobe.
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            cfg_en_r   <= 1'b0;
            cfg_pol_r  <= 1'b0;
            cfg_auto_r <= 1'b0;
            rearm_r    <= 1'b0;
            min_r      <= 14'sd0;
            max_r      <= 14'sd0;
            thr_r      <= 14'sd0;
            step_r     <= {STEPBITS{1'b0}};
            hold_r     <= {HOLDBITS{1'b0}};
        end else begin
            rearm_r <= wen && (addr == ADDR_CFG) && wdata[3];
            if (wen) begin
                case (addr)
                    ADDR_CFG: begin
                        cfg_en_r   <= wdata[0];
                        cfg_pol_r  <= wdata[1];
                        cfg_auto_r <= wdata[2];
                    end
                    ADDR_MIN:  min_r  <= wdata[13:0];
                    ADDR_MAX:  max_r  <= wdata[13:0];
                    ADDR_STEP: step_r <= wdata[STEPBITS-1:0];
                    ADDR_THR:  thr_r  <= wdata[13:0];
                    ADDR_HOLD: hold_r <= wdata[HOLDBITS-1:0];
                    default: begin
                    end
                endcase
            end
        end
    end

    // Read data multiplexer; unmapped addresses read as zero.
    always_comb begin
        case (addr)
            ADDR_CFG:    rd_mux_s = {29'd0, cfg_auto_r, cfg_pol_r, cfg_en_r};
            ADDR_MIN:    rd_mux_s = {18'd0, min_r};
            ADDR_MAX:    rd_mux_s = {18'd0, max_r};
            ADDR_STEP:   rd_mux_s = 32'(step_r);
            ADDR_THR:    rd_mux_s = {18'd0, thr_r};
            ADDR_HOLD:   rd_mux_s = 32'(hold_r);
            ADDR_STATUS: rd_mux_s = {{2{dat_o[13]}}, dat_o, 13'd0, dir_r, state_r};
            ADDR_TRIGC:  rd_mux_s = {16'd0, trig_cnt_r};
            default:     rd_mux_s = 32'd0;
        endcase
    end

    // Bus acknowledge and read data, one cycle after the strobe.
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            ack_r   <= 1'b0;
            rdata_r <= 32'd0;
        end else begin
            ack_r   <= wen | ren;
            rdata_r <= ren ? rd_mux_s : 32'd0;
        end
    end

endmodule

// File: tb/tb_red_pitaya_sweep_block.sv
// Self-checking bench for red_pitaya_sweep_block against a value-level model.
module tb_red_pitaya_sweep_block;

    logic               clk = 1'b0;
    logic               rstn;
    logic signed [13:0] dat_i;
    logic signed [13:0] dat_o;
    logic [15:0]        addr;
    logic               wen, ren, ack;
    logic [31:0]        rdata, wdata;

    int n_checks = 0;
    int n_pass   = 0;

    red_pitaya_sweep_block dut (
        .clk_i (clk),
        .rstn_i(rstn),
        .dat_i (dat_i),
        .dat_o (dat_o),
        .addr  (addr),
        .wen   (wen),
        .ren   (ren),
        .ack   (ack),
        .rdata (rdata),
        .wdata (wdata)
    );

    always #5 clk = ~clk;

    // Reference model: accumulator in units of 2^-16 LSB, plain integers.
    int          m_state, m_dir, m_tc, m_min, m_max, m_th, m_d1, m_d2;
    longint      m_acc, m_step, m_hold, m_cnt;
    bit          m_en, m_pol, m_auto, m_rearm, m_trig, m_ack;
    logic [31:0] m_rdata;
    logic [13:0] m_dato;

    task automatic model_edge(input bit rst, input bit w, input bit r,
                              input logic [15:0] a, input logic [31:0] wd, input int din);
        longint lo, hi, s, lim;
        int n_state, n_dir, n_tc;
        longint n_acc, n_cnt;
        bit n_trig;
        logic [31:0] rd;
        logic [15:0] d16;
        if (!rst) begin
            m_state = 0; m_dir = 0; m_tc = 0; m_min = 0; m_max = 0; m_th = 0;
            m_d1 = 0; m_d2 = 0; m_acc = 0; m_step = 0; m_hold = 0; m_cnt = 0;
            m_en = 0; m_pol = 0; m_auto = 0; m_rearm = 0; m_trig = 0;
            m_ack = 0; m_rdata = 32'd0; m_dato = 14'd0;
            return;
        end
        d16 = 16'(m_acc >>> 16);
        case (a)
            16'h0100: rd = {29'd0, m_auto, m_pol, m_en};
            16'h0104: rd = 32'(m_min) & 32'h3FFF;
            16'h0108: rd = 32'(m_max) & 32'h3FFF;
            16'h010C: rd = 32'(m_step);
            16'h0110: rd = 32'(m_th) & 32'h3FFF;
            16'h0114: rd = 32'(m_hold);
            16'h0118: rd = {d16, 13'd0, m_dir[0], m_state[1:0]};
            16'h011C: rd = 32'(m_tc);
            default:  rd = 32'd0;
        endcase
        lo = longint'(m_min) * 65536;
        hi = longint'((m_max > m_min) ? m_max : m_min) * 65536;
        n_state = m_state; n_dir = m_dir; n_tc = m_tc; n_acc = m_acc; n_cnt = m_cnt;
        if (!m_en) begin
            n_state = 0; n_acc = lo; n_dir = 0; n_tc = 0; n_cnt = 0;
        end else if (m_state == 0) begin
            n_state = 1; n_acc = lo; n_dir = 0;
        end else if (m_state == 1 || m_state == 2) begin
            s = (m_state == 1) ? m_acc + m_step : m_acc - m_step;
            if ((m_state == 1 && s >= hi) || (m_state == 2 && s <= lo)) begin
                n_dir = (m_state == 1) ? 1 : 0;
                if (!m_trig) begin
                    n_acc   = (m_state == 1) ? hi : lo;
                    n_state = (m_state == 1) ? 2 : 1;
                end
            end else if (!m_trig) begin
                n_acc = s;
            end
            if (m_trig) begin
                n_state = 3; n_cnt = 0;
                n_tc = (m_tc < 65535) ? m_tc + 1 : m_tc;
            end
        end else begin
            lim = (m_hold == 0) ? 0 : m_hold - 1;
            n_cnt = m_cnt + 1;
            if (m_rearm || (m_auto && m_cnt == lim)) n_state = (m_dir == 1) ? 2 : 1;
        end
        n_trig = m_pol ? (m_d2 > m_th && m_d1 <= m_th) : (m_d2 < m_th && m_d1 >= m_th);
        m_d2 = m_d1; m_d1 = din; m_trig = n_trig;
        m_rearm = w && (a == 16'h0100) && wd[3];
        if (w) begin
            case (a)
                16'h0100: begin m_en = wd[0]; m_pol = wd[1]; m_auto = wd[2]; end
                16'h0104: m_min  = int'($signed(wd[13:0]));
                16'h0108: m_max  = int'($signed(wd[13:0]));
                16'h010C: m_step = longint'(wd[23:0]);
                16'h0110: m_th   = int'($signed(wd[13:0]));
                16'h0114: m_hold = longint'(wd);
                default: ;
            endcase
        end
        m_ack = w | r;
        m_rdata = r ? rd : 32'd0;
        m_state = n_state; m_dir = n_dir; m_tc = n_tc; m_acc = n_acc; m_cnt = n_cnt;
        m_dato = 14'(m_acc >>> 16);
    endtask

    task automatic tick();
        bit c_rst = rstn, c_w = wen, c_r = ren;
        logic [15:0] c_a = addr;
        logic [31:0] c_wd = wdata;
        int c_din = int'(dat_i);
        @(posedge clk);
        model_edge(c_rst, c_w, c_r, c_a, c_wd, c_din);
        #1;
    endtask

    task automatic do_reset();
        rstn = 1'b0; wen = 1'b0; ren = 1'b0;
        tick(); tick();
        rstn = 1'b1;
    endtask

    task automatic bus_write(input logic [15:0] a, input logic [31:0] d);
        addr = a; wdata = d; wen = 1'b1;
        tick();
        wen = 1'b0;
    endtask

    task automatic bus_read(input logic [15:0] a);
        addr = a; ren = 1'b1;
        tick();
        ren = 1'b0;
    endtask

    task automatic setup_sweep(input int mn, input int mx, input logic [31:0] st, input logic [31:0] cfg);
        bus_write(16'h0104, 32'(mn) & 32'h3FFF);
        bus_write(16'h0108, 32'(mx) & 32'h3FFF);
        bus_write(16'h010C, st);
        bus_write(16'h0100, cfg);
    endtask

    task automatic test_reset();
        dat_i = 14'sd0; addr = 16'd0; wdata = 32'd0;
        do_reset();
        n_checks++;
        if (dat_o !== 14'sd0 || ack !== 1'b0 || rdata !== 32'd0)
            $display("FAIL reset_outputs: got dat_o=%0d ack=%0b rdata=%h, expected 0/0/0", dat_o, ack, rdata);
        else n_pass++;
        for (int i = 0; i < 8; i++) begin
            bus_read(16'h0100 + 16'(i * 4));
            n_checks++;
            if (ack !== 1'b1 || rdata !== 32'd0)
                $display("FAIL reset_reg_%0d: got ack=%0b rdata=%h, expected 1/00000000", i, ack, rdata);
            else n_pass++;
        end
    endtask

    task automatic test_sweep();
        int mx = -9999, mn = 9999, last_top = -1, period = 0, v;
        dat_i = -14'sd10;
        do_reset();
        setup_sweep(-100, 100, 32'h10000, 32'h1);
        for (int i = 0; i < 900; i++) begin
            tick();
            n_checks++;
            if (dat_o !== m_dato) $display("FAIL sweep_dat_o cyc %0d: got %0d expected %0d", i, dat_o, $signed(m_dato));
            else n_pass++;
            v = int'(dat_o);
            if (v > mx) mx = v;
            if (v < mn) mn = v;
            if (v == 100) begin
                if (last_top >= 0) period = i - last_top;
                last_top = i;
            end
        end
        n_checks++;
        if (mx !== 100 || mn !== -100 || period !== 400)
            $display("FAIL sweep_extent: got max=%0d min=%0d period=%0d expected 100/-100/400", mx, mn, period);
        else n_pass++;
    endtask

    task automatic test_frac_step();
        int exp4[4] = '{-100, -99, -97, -96};
        int mx = -9999;
        dat_i = -14'sd10;
        do_reset();
        setup_sweep(-100, 100, 32'h18000, 32'h1);
        for (int i = 0; i < 4; i++) begin
            tick();
            n_checks++;
            if (int'(dat_o) !== exp4[i]) $display("FAIL frac_start_%0d: got %0d expected %0d", i, dat_o, exp4[i]);
            else n_pass++;
        end
        for (int i = 0; i < 300; i++) begin
            tick();
            if (int'(dat_o) > mx) mx = int'(dat_o);
            n_checks++;
            if (dat_o !== m_dato) $display("FAIL frac_dat_o cyc %0d: got %0d expected %0d", i, dat_o, $signed(m_dato));
            else n_pass++;
        end
        n_checks++;
        if (mx !== 100) $display("FAIL frac_peak: got %0d expected 100", mx);
        else n_pass++;
    endtask

    task automatic test_trigger_and_rearm();
        logic [13:0] frozen;
        dat_i = -14'sd10;
        do_reset();
        setup_sweep(-100, 100, 32'h10000, 32'h1);
        for (int i = 0; i < 50; i++) tick();
        dat_i = 14'sd10;
        tick(); tick();
        frozen = m_dato;
        bus_read(16'h0118);
        n_checks++;
        if (rdata[1:0] !== 2'd1) $display("FAIL trig_not_yet: got state %0d expected 1", rdata[1:0]);
        else n_pass++;
        bus_read(16'h0118);
        n_checks++;
        if (rdata[1:0] !== 2'd3 || rdata !== m_rdata)
            $display("FAIL trig_hold_k3: got %h expected state 3, word %h", rdata, m_rdata);
        else n_pass++;
        for (int i = 0; i < 8; i++) tick();
        n_checks++;
        if (dat_o !== frozen) $display("FAIL trig_frozen: got %0d expected %0d", dat_o, $signed(frozen));
        else n_pass++;
        bus_read(16'h011C);
        n_checks++;
        if (rdata !== 32'd1) $display("FAIL trig_count: got %0d expected 1", rdata);
        else n_pass++;
        bus_write(16'h0100, 32'h9);
        bus_read(16'h0118);
        n_checks++;
        if (rdata[1:0] !== 2'd3) $display("FAIL rearm_same_edge: got state %0d expected 3", rdata[1:0]);
        else n_pass++;
        bus_read(16'h0118);
        n_checks++;
        if (rdata[1:0] !== 2'd1) $display("FAIL rearm_resume: got state %0d expected 1", rdata[1:0]);
        else n_pass++;
        dat_i = -14'sd10;
        for (int i = 0; i < 6; i++) tick();
        bus_read(16'h011C);
        n_checks++;
        if (rdata !== 32'd1) $display("FAIL falling_ignored: got count %0d expected 1", rdata);
        else n_pass++;
        n_checks++;
        if (dat_o !== m_dato) $display("FAIL rearm_dat_o: got %0d expected %0d", dat_o, $signed(m_dato));
        else n_pass++;
        // disable mid-UP
        bus_write(16'h0100, 32'h0);
        tick();
        n_checks++;
        if (dat_o !== -14'sd100) $display("FAIL disable_dat_o: got %0d expected -100", dat_o);
        else n_pass++;
        bus_read(16'h011C);
        n_checks++;
        if (rdata !== 32'd0) $display("FAIL disable_count: got %0d expected 0", rdata);
        else n_pass++;
    endtask

    task automatic test_auto_rearm();
        int seen;
        dat_i = -14'sd10;
        do_reset();
        bus_write(16'h0114, 32'd5);
        setup_sweep(-20, 20, 32'h10000, 32'h5);
        for (int i = 0; i < 60; i++) tick();
        for (int pass = 0; pass < 2; pass++) begin
            seen = 0;
            addr = 16'h0118; ren = 1'b1; dat_i = 14'sd10;
            for (int i = 0; i < 16; i++) begin
                tick();
                if (ack === 1'b1 && rdata[1:0] === 2'd3) seen++;
                n_checks++;
                if (dat_o !== m_dato || rdata !== m_rdata)
                    $display("FAIL auto_cyc p%0d c%0d: got %0d/%h expected %0d/%h", pass, i, dat_o, rdata, $signed(m_dato), m_rdata);
                else n_pass++;
            end
            ren = 1'b0;
            n_checks++;
            if (seen !== ((pass == 0) ? 5 : 1))
                $display("FAIL auto_hold_len p%0d: got %0d expected %0d", pass, seen, (pass == 0) ? 5 : 1);
            else n_pass++;
            dat_i = -14'sd10;
            bus_write(16'h0114, 32'd0);
            for (int i = 0; i < 4; i++) tick();
        end
    endtask

    task automatic test_boundaries();
        do_reset();
        dat_i = -14'sd10;
        setup_sweep(50, 20, 32'h10000, 32'h1);
        addr = 16'h0118; ren = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick();
            n_checks++;
            if (dat_o !== 14'sd50 || rdata !== m_rdata)
                $display("FAIL pinned_min c%0d: got %0d/%h expected 50/%h", i, dat_o, rdata, m_rdata);
            else n_pass++;
        end
        ren = 1'b0;
        do_reset();
        setup_sweep(-100, 100, 32'h0, 32'h1);
        for (int i = 0; i < 12; i++) begin
            tick();
            n_checks++;
            if (dat_o !== -14'sd100) $display("FAIL step_zero c%0d: got %0d expected -100", i, dat_o);
            else n_pass++;
        end
    endtask

    task automatic test_bus();
        do_reset();
        bus_write(16'h0104, 32'h3F9C);
        bus_read(16'h0104);
        n_checks++;
        if (ack !== 1'b1 || rdata !== 32'h3F9C) $display("FAIL bus_min_rd: got ack=%0b rdata=%h expected 1/00003f9c", ack, rdata);
        else n_pass++;
        tick();
        n_checks++;
        if (ack !== 1'b0) $display("FAIL bus_ack_drop: got %0b expected 0", ack);
        else n_pass++;
        bus_read(16'h0200);
        n_checks++;
        if (ack !== 1'b1 || rdata !== 32'd0) $display("FAIL bus_unmapped: got ack=%0b rdata=%h expected 1/00000000", ack, rdata);
        else n_pass++;
    endtask

    task automatic test_random();
        int th, v;
        for (int sc = 0; sc < 4; sc++) begin
            do_reset();
            th = int'($urandom_range(0, 8000)) - 4000;
            dat_i = 14'(th);
            bus_write(16'h0110, 32'(th) & 32'h3FFF);
            bus_write(16'h0114, 32'($urandom_range(0, 6)));
            setup_sweep(int'($urandom_range(0, 12000)) - 6000, int'($urandom_range(0, 12000)) - 6000,
                        32'($urandom_range(0, 32'h3FFFFF)), {29'd0, 1'b1, 1'($urandom_range(0, 1)), 1'b1});
            for (int i = 0; i < 400; i++) begin
                v = th + int'($urandom_range(0, 40)) - 20;
                dat_i = 14'(v);
                ren = ($urandom_range(0, 3) == 0);
                addr = ($urandom_range(0, 8) == 8) ? 16'h0200 : 16'h0100 + 16'($urandom_range(0, 7) * 4);
                tick();
                n_checks++;
                if (dat_o !== m_dato || ack !== m_ack || rdata !== m_rdata)
                    $display("FAIL random s%0d c%0d: got %0d/%0b/%h expected %0d/%0b/%h",
                             sc, i, dat_o, ack, rdata, $signed(m_dato), m_ack, m_rdata);
                else n_pass++;
            end
            ren = 1'b0;
        end
    endtask

    initial begin
        rstn = 1'b0; wen = 1'b0; ren = 1'b0; addr = 16'd0; wdata = 32'd0; dat_i = 14'sd0;
        test_reset();
        test_bus();
        test_sweep();
        test_frac_step();
        test_trigger_and_rearm();
        test_auto_rearm();
        test_boundaries();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
